// File: rtl/decryption_dispatcher.sv
// Decryption front-end: buffers ciphertext characters and streams each
// message to the one engine selected at message start.
module decryption_dispatcher #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter logic [DATA_WIDTH-1:0] END_CHAR = 8'hFA,
    parameter int GUARD_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  valid_i,
    output logic                  busy_o,
    input  logic [1:0]            select_i,
    input  logic [2:0]            eng_busy_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic [2:0]            valid_o,
    output logic [1:0]            active_sel_o,
    output logic                  in_msg_o,
    output logic                  sel_error_o,
    output logic                  overflow_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int GW = $clog2(GUARD_CYCLES + 2);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_STREAM  = 2'd1;
    localparam logic [1:0] S_WAIT    = 2'd2;
    localparam logic [1:0] S_DISCARD = 2'd3;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic [CW-1:0]         count_next;
    logic [1:0]            state;
    logic [1:0]            sel_q;
    logic [GW-1:0]         guard_q;
    logic [DATA_WIDTH-1:0] head;
    logic                  empty;
    logic                  full;
    logic                  push;
    logic                  pop;
    logic                  is_end;
    logic                  eng_busy_sel;

    assign head         = mem[rd_ptr];
    assign empty        = (count == '0);
    assign full         = (count == CW'(FIFO_DEPTH));
    assign push         = valid_i && !full;
    assign is_end       = (head == END_CHAR);
    assign active_sel_o = sel_q;

    // Busy of the latched engine only; the others never stall us.
    always_comb begin
        eng_busy_sel = 1'b0;
        case (sel_q)
            2'd0:    eng_busy_sel = eng_busy_i[0];
            2'd1:    eng_busy_sel = eng_busy_i[1];
            2'd2:    eng_busy_sel = eng_busy_i[2];
            default: eng_busy_sel = 1'b0;
        endcase
    end

    // Pop decision and next occupancy.
    always_comb begin
        pop = !empty &&
              (((state == S_STREAM) && !eng_busy_sel) ||
               (state == S_DISCARD));
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    // FIFO storage; contents need no reset, occupancy gates reads.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= data_i;
    end

    // FIFO pointers, occupancy, full flag and sticky overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            busy_o     <= 1'b0;
            overflow_o <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count  <= count_next;
            busy_o <= (count_next == CW'(FIFO_DEPTH));
            if (valid_i && full) overflow_o <= 1'b1;
        end
    end

    // Message sequencer: latch select, stream, guard, or discard.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            sel_q       <= 2'd0;
            guard_q     <= '0;
            data_o      <= '0;
            valid_o     <= '0;
            in_msg_o    <= 1'b0;
            sel_error_o <= 1'b0;
        end else begin
            valid_o     <= '0;
            sel_error_o <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (!empty) begin
                        sel_q    <= select_i;
                        in_msg_o <= 1'b1;
                        if (select_i == 2'd3) begin
                            sel_error_o <= 1'b1;
                            state       <= S_DISCARD;
                        end else begin
                            state <= S_STREAM;
                        end
                    end
                end
                S_STREAM: begin
                    if (pop) begin
                        data_o  <= head;
                        valid_o <= 3'(3'b001 << sel_q);
                        if (is_end) begin
                            state   <= S_WAIT;
                            guard_q <= '0;
                        end
                    end
                end
                S_WAIT: begin
                    if (guard_q >= GW'(GUARD_CYCLES) && !eng_busy_sel) begin
                        state    <= S_IDLE;
                        in_msg_o <= 1'b0;
                    end else if (guard_q < GW'(GUARD_CYCLES)) begin
                        guard_q <= guard_q + GW'(1);
                    end
                end
                S_DISCARD: begin
                    if (pop && is_end) begin
                        state    <= S_IDLE;
                        in_msg_o <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_decryption_dispatcher.sv
// Directed bench for decryption_dispatcher with a strobe scoreboard.
// Expected strobes are queued as stimulus is driven.
module tb_decryption_dispatcher;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_i = '0;
    logic       valid_i = 1'b0;
    logic       busy_o;
    logic [1:0] select_i = '0;
    logic [2:0] eng_busy_i = '0;
    logic [7:0] data_o;
    logic [2:0] valid_o;
    logic [1:0] active_sel_o;
    logic       in_msg_o;
    logic       sel_error_o;
    logic       overflow_o;

    int checks = 0;
    int errors = 0;
    int sel_err_cnt = 0;
    logic [10:0] sb[$];

    decryption_dispatcher dut (
        .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i),
        .busy_o(busy_o), .select_i(select_i), .eng_busy_i(eng_busy_i),
        .data_o(data_o), .valid_o(valid_o), .active_sel_o(active_sel_o),
        .in_msg_o(in_msg_o), .sel_error_o(sel_error_o),
        .overflow_o(overflow_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one character and optionally queue its expected strobe.
    task automatic send(input logic [7:0] d, input logic [2:0] mask);
        valid_i = 1'b1;
        data_i  = d;
        if (mask != 3'b000) sb.push_back({mask, d});
        step();
        valid_i = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 80 && (sb.size() != 0 || in_msg_o); i++)
            @(negedge clk);
        chk(tag, 32'(sb.size() == 0 && !in_msg_o), 32'd1);
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({busy_o, data_o, valid_o, active_sel_o,
                    in_msg_o, sel_error_o, overflow_o});
    endfunction

    // Scoreboard monitor: every strobe must match the queue head.
    always @(negedge clk) begin
        if (!rst) begin
            if (sel_error_o) sel_err_cnt++;
            if (valid_o != 3'b000) begin
                if (sb.size() == 0) begin
                    chk("unexpected_strobe", 32'({valid_o, data_o}), 32'd0);
                end else begin
                    chk("strobe", 32'({valid_o, data_o}),
                        32'(sb.pop_front()));
                end
            end
        end
    end

    initial begin
        // Reset then idle
        #1;
        chk("in_reset", all_outs(), 32'd0);
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_outs", all_outs(), 32'd0);
        end

        // Caesar stream with latency and guard timing
        step();
        select_i = 2'd0;
        send(8'h41, 3'b001);
        valid_i = 1'b1; data_i = 8'h42; sb.push_back({3'b001, 8'h42});
        step();
        data_i = 8'hFA; sb.push_back({3'b001, 8'hFA});
        step();
        valid_i = 1'b0;
        @(negedge clk);
        chk("caesar_first_valid", 32'(valid_o), 32'b001);
        chk("caesar_first_data", 32'(data_o), 32'h41);
        step(); step(); step(); step();
        chk("caesar_in_msg_guard", 32'(in_msg_o), 32'd1);
        step();
        chk("caesar_in_msg_fall", 32'(in_msg_o), 32'd0);
        chk("caesar_active_sel", 32'(active_sel_o), 32'd0);
        drain("caesar_drain");

        // Engine stall plus FIFO full
        step();
        select_i = 2'd1;
        eng_busy_i = 3'b010;
        send(8'h51, 3'b010);
        send(8'h52, 3'b010);
        send(8'h53, 3'b010);
        chk("stall_busy_3", 32'(busy_o), 32'd0);
        send(8'hFA, 3'b010);
        chk("stall_busy_4", 32'(busy_o), 32'd1);
        chk("stall_ovf_before", 32'(overflow_o), 32'd0);
        send(8'h54, 3'b000);
        chk("stall_ovf_after", 32'(overflow_o), 32'd1);
        chk("stall_busy_5", 32'(busy_o), 32'd1);
        chk("stall_no_strobe", 32'(sb.size()), 32'd4);
        eng_busy_i = 3'b000;
        drain("stall_drain");
        chk("stall_ovf_sticky", 32'(overflow_o), 32'd1);

        // Select locked mid-message
        step();
        select_i = 2'd2;
        send(8'h61, 3'b100);
        send(8'h62, 3'b100);
        send(8'h63, 3'b100);
        select_i = 2'd0;
        chk("lock_first_strobe", 32'(valid_o), 32'b100);
        send(8'hFA, 3'b100);
        chk("lock_active_sel_mid", 32'(active_sel_o), 32'd2);
        drain("lock_drain");
        chk("lock_active_sel_end", 32'(active_sel_o), 32'd2);

        // Invalid select then a valid message
        step();
        sel_err_cnt = 0;
        select_i = 2'd3;
        send(8'h10, 3'b000);
        send(8'hFA, 3'b000);
        select_i = 2'd0;
        send(8'h33, 3'b001);
        send(8'hFA, 3'b001);
        drain("invalid_drain");
        chk("invalid_sel_err_pulses", 32'(sel_err_cnt), 32'd1);
        chk("invalid_active_sel", 32'(active_sel_o), 32'd0);

        // Reset mid-message while stalled in STREAM
        step();
        select_i = 2'd0;
        eng_busy_i = 3'b001;
        send(8'h71, 3'b000);
        send(8'h72, 3'b000);
        step();
        chk("rst_mid_in_msg", 32'(in_msg_o), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_mid_async", all_outs(), 32'd0);
        step();
        rst = 1'b0;
        eng_busy_i = 3'b000;
        step();
        chk("rst_after_outs", all_outs(), 32'd0);
        select_i = 2'd1;
        send(8'h81, 3'b010);
        send(8'hFA, 3'b010);
        drain("rst_next_msg");
        chk("rst_next_sel", 32'(active_sel_o), 32'd1);

        repeat (3) step();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
